// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters:
// combinational lookup on the fetch PC, training and mispredict resolution in execute.
// Optional BranchCount/MispredictCount statistics are present only when BP_STATS_EN is defined.
module branch_predictor #(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] PCF,
    output logic             PredTakenF,
    output logic [WIDTH-1:0] PredTargetF,
    input  logic             ValidE,
    input  logic             BranchE,
    input  logic             TakenE,
    input  logic [WIDTH-1:0] TargetE,
    input  logic [WIDTH-1:0] PCE,
    input  logic [WIDTH-1:0] PCPlus4E,
    input  logic             PredTakenE,
    input  logic [WIDTH-1:0] PredTargetE,
    output logic             flushBranch,
    output logic [WIDTH-1:0] RedirectPCE
`ifdef BP_STATS_EN
    ,
    output logic [31:0]      BranchCount,
    output logic [31:0]      MispredictCount
`endif
);

    localparam int TAG_BITS = WIDTH - 2 - INDEX_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [WIDTH-1:0]    r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];

    logic [INDEX_BITS-1:0] w_idx_f;
    logic [TAG_BITS-1:0]   w_tag_f;
    logic                  w_hit_f;
    logic [INDEX_BITS-1:0] w_idx_e;
    logic [TAG_BITS-1:0]   w_tag_e;
    logic                  w_hit_e;
    logic                  w_mis_dir;
    logic                  w_mis_tgt;
    logic                  w_mis_alias;
    logic                  w_unused;

    // Word-aligned PCs: the two low bits never take part in indexing or tagging.
    assign w_unused = &{1'b0, PCF[1:0], PCE[1:0]};

    assign w_idx_f = PCF[INDEX_BITS+1:2];
    assign w_tag_f = PCF[WIDTH-1:INDEX_BITS+2];
    assign w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);

    assign PredTakenF  = w_hit_f && r_ctr[w_idx_f][1];
    assign PredTargetF = PredTakenF ? r_target[w_idx_f] : '0;

    assign w_idx_e = PCE[INDEX_BITS+1:2];
    assign w_tag_e = PCE[WIDTH-1:INDEX_BITS+2];
    assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

    assign w_mis_dir   = BranchE && (TakenE != PredTakenE);
    assign w_mis_tgt   = BranchE && TakenE && PredTakenE && (TargetE != PredTargetE);
    assign w_mis_alias = !BranchE && PredTakenE;

    always_comb begin
        flushBranch = 1'b0;
        RedirectPCE = '0;
        if (ValidE && rst_n && (w_mis_dir || w_mis_tgt || w_mis_alias)) begin
            flushBranch = 1'b1;
            // A non-branch never redirects to TargetE, whatever TakenE says.
            RedirectPCE = (BranchE && TakenE) ? TargetE : PCPlus4E;
        end
    end

    // Tag and target need no reset: they are only read behind a set valid bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (ValidE) begin
            if (BranchE) begin
                if (TakenE) begin
                    if (w_hit_e) begin
                        if (r_ctr[w_idx_e] != 2'b11) begin
                            r_ctr[w_idx_e] <= r_ctr[w_idx_e] + 2'd1;
                        end
                        r_target[w_idx_e] <= TargetE;
                    end else begin
                        r_valid[w_idx_e]  <= 1'b1;
                        r_tag[w_idx_e]    <= w_tag_e;
                        r_target[w_idx_e] <= TargetE;
                        r_ctr[w_idx_e]    <= 2'b10;
                    end
                end else if (w_hit_e && (r_ctr[w_idx_e] != 2'b00)) begin
                    r_ctr[w_idx_e] <= r_ctr[w_idx_e] - 2'd1;
                end
            end else if (w_hit_e) begin
                r_valid[w_idx_e] <= 1'b0;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            BranchCount     <= '0;
            MispredictCount <= '0;
        end else begin
            if (ValidE && BranchE) begin
                BranchCount <= BranchCount + 32'd1;
            end
            if (flushBranch) begin
                MispredictCount <= MispredictCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, training, hysteresis, alias,
// target change, bubble and mid-stream reset; statistics checked when BP_STATS_EN is defined.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        ValidE;
    logic        BranchE;
    logic        TakenE;
    logic [31:0] TargetE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        flushBranch;
    logic [31:0] RedirectPCE;
`ifdef BP_STATS_EN
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;
`endif

    int test_count = 0;
    int fail_count = 0;
    int exp_branches = 0;
    int exp_misp = 0;

    branch_predictor #(.WIDTH(32), .INDEX_BITS(6)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PCF             (PCF),
        .PredTakenF      (PredTakenF),
        .PredTargetF     (PredTargetF),
        .ValidE          (ValidE),
        .BranchE         (BranchE),
        .TakenE          (TakenE),
        .TargetE         (TargetE),
        .PCE             (PCE),
        .PCPlus4E        (PCPlus4E),
        .PredTakenE      (PredTakenE),
        .PredTargetE     (PredTargetE),
        .flushBranch     (flushBranch),
        .RedirectPCE     (RedirectPCE)
`ifdef BP_STATS_EN
        ,
        .BranchCount     (BranchCount),
        .MispredictCount (MispredictCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_e(input logic [31:0] pc, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        @(negedge clk);
        ValidE      = 1'b1;
        PCE         = pc;
        PCPlus4E    = pc + 32'd4;
        BranchE     = br;
        TakenE      = tk;
        TargetE     = tgt;
        PredTakenE  = ptk;
        PredTargetE = ptgt;
    endtask

    task automatic check_e(input string tag, input logic exp_flush, input logic [31:0] exp_redir);
        #1;
        check({tag, "_flush"}, {31'd0, flushBranch}, {31'd0, exp_flush});
        check({tag, "_redir"}, RedirectPCE, exp_redir);
        if (ValidE && rst_n && BranchE) exp_branches++;
        if (exp_flush) exp_misp++;
    endtask

    task automatic end_e();
        @(posedge clk);
        #1;
        ValidE = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [31:0] pc, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                         input logic exp_flush, input logic [31:0] exp_redir);
        set_e(pc, br, tk, tgt, ptk, ptgt);
        check_e(tag, exp_flush, exp_redir);
        end_e();
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_taken, input logic [31:0] exp_tgt);
        @(negedge clk);
        PCF = pc;
        #1;
        check({tag, "_taken"}, {31'd0, PredTakenF}, {31'd0, exp_taken});
        check({tag, "_target"}, PredTargetF, exp_tgt);
    endtask

    initial begin
        rst_n = 1'b0;
        PCF = '0; ValidE = 1'b0; BranchE = 1'b0; TakenE = 1'b0;
        TargetE = '0; PCE = '0; PCPlus4E = '0; PredTakenE = 1'b0; PredTargetE = '0;
        repeat (3) @(posedge clk);

        // Flush stays low while reset is held, even with a mispredicting E op.
        set_e(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        #1;
        check("rst_flush", {31'd0, flushBranch}, 32'd0);
        check("rst_redir", RedirectPCE, 32'h0);
        end_e();
        rst_n = 1'b1;

        lookup("cold", 32'h100, 1'b0, 32'h0);

        // First taken branch; same-cycle lookup sees the pre-update entry.
        set_e(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        PCF = 32'h100;
        check_e("first", 1'b1, 32'h200);
        check("nobypass_taken", {31'd0, PredTakenF}, 32'd0);
        end_e();
        lookup("trained", 32'h100, 1'b1, 32'h200);

        // Hysteresis: 10 -> 11 -> 10 -> 01 -> 00 (sat) -> 01 -> 10.
        issue("hit_ok", 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
        issue("nt1", 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104);
        lookup("hyst1", 32'h100, 1'b1, 32'h200);
        issue("nt2", 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104);
        lookup("hyst2", 32'h100, 1'b0, 32'h0);
        issue("nt3", 32'h100, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
        issue("tk_from00", 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
        lookup("sat_low", 32'h100, 1'b0, 32'h0);
        issue("tk_from01", 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
        lookup("rearmed", 32'h100, 1'b1, 32'h200);

        // Target change on a predicted-taken hit.
        issue("tgt_chg", 32'h100, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 32'h300);
        lookup("new_tgt", 32'h100, 1'b1, 32'h300);

        // Alias from a non-branch with a different tag at the same index.
        issue("alias", 32'h1100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h1104);
        lookup("alias_miss", 32'h1100, 1'b0, 32'h0);
        // Non-branch at the trained PC invalidates its entry.
        issue("nonbr_hit", 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h104);
        lookup("invalidated", 32'h100, 1'b0, 32'h0);
        issue("nt_miss", 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        lookup("nt_miss_nochg", 32'h100, 1'b0, 32'h0);

        // Bubble with mismatching inputs: no flush, table unchanged.
        issue("train140", 32'h140, 1'b1, 1'b1, 32'h480, 1'b0, 32'h0, 1'b1, 32'h480);
        lookup("t140", 32'h140, 1'b1, 32'h480);
        set_e(32'h140, 1'b0, 1'b1, 32'h999, 1'b1, 32'h480);
        ValidE = 1'b0;
        #1;
        check("bubble_flush", {31'd0, flushBranch}, 32'd0);
        check("bubble_redir", RedirectPCE, 32'h0);
        end_e();
        lookup("bubble_keep", 32'h140, 1'b1, 32'h480);

`ifdef BP_STATS_EN
        check("branch_count", BranchCount, exp_branches);
        check("misp_count", MispredictCount, exp_misp);
`endif

        // Mid-stream reset discards the pending update and clears the table.
        set_e(32'h180, 1'b1, 1'b1, 32'h600, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("midrst_flush", {31'd0, flushBranch}, 32'd0);
        check("midrst_redir", RedirectPCE, 32'h0);
        end_e();
        rst_n = 1'b1;
        lookup("rst_180", 32'h180, 1'b0, 32'h0);
        lookup("rst_140", 32'h140, 1'b0, 32'h0);
`ifdef BP_STATS_EN
        check("rst_branch_count", BranchCount, 32'd0);
        check("rst_misp_count", MispredictCount, 32'd0);
`endif
        issue("post_rst", 32'h140, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h500);
        lookup("post_rst_lk", 32'h140, 1'b1, 32'h500);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
